// File: rtl/fetch_pkg.sv
// Shared state type and constants for the RV32I instruction-fetch controller.
// With MISALIGN_TRAP_EN defined, the state type gains S_HALT for the misaligned-redirect trap.
package fetch_pkg;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1
  } fetch_state_e;
`endif

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry output register between fetch and decode: holds valid/pc/instr and
// a registered pc+4 so every decode-facing output comes straight from a flop.
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_load,
  input  logic [31:0] i_load_pc,
  input  logic [31:0] i_load_instr,
  input  logic        i_consume,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic [31:0] o_instr
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic [31:0] r_instr;

  // Flush beats load beats consume; pc/instr keep their last value when invalidated.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0000_0000;
      r_pc4   <= PC_INC;
      r_instr <= NOP_INSTR;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_load_pc;
      r_pc4   <= i_load_pc + PC_INC;
      r_instr <= i_load_instr;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, keeps one imem request in flight,
// applies execute redirects and drops stale responses. Optional feature macro: MISALIGN_TRAP_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc4,
  output logic [31:0] o_if_instr,
  output logic        o_misalign
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_next_pc;
  logic [31:0]  w_redir_pc;
  logic         r_kill;
  logic         w_next_kill;
  logic         w_capture;
  logic         w_drain;
  logic         w_consume;
  logic         w_granted;
  logic         w_if_valid;

`ifdef MISALIGN_TRAP_EN
  logic w_misaligned;
  logic w_next_misalign;
  logic r_misalign;
  assign w_redir_pc   = i_redirect_pc;
  assign w_misaligned = |i_redirect_pc[1:0];
`else
  assign w_redir_pc   = i_redirect_pc & PC_ALIGN_MASK;
`endif

  // A new request is only offered when its response will have somewhere to land.
  assign w_consume   = w_if_valid && !i_stall;
  assign w_drain     = !w_if_valid || !i_stall;
  assign o_imem_req  = (r_state == S_REQ) && w_drain;
  assign o_imem_addr = r_pc;
  assign w_granted   = o_imem_req && i_imem_gnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_kill  <= w_next_kill;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_kill  = r_kill;
    w_capture    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    w_next_misalign = 1'b0;
`endif
    case (r_state)
      S_REQ: begin
        if (w_granted) w_next_state = S_RESP;
      end
      S_RESP: begin
        if (i_imem_rvalid) begin
          w_next_state = S_REQ;
          w_next_kill  = 1'b0;
          if (!r_kill) begin
            w_capture = 1'b1;
            w_next_pc = r_pc + PC_INC;
          end
        end
      end
`ifdef MISALIGN_TRAP_EN
      S_HALT: begin
        if (i_imem_rvalid) w_next_kill = 1'b0;
      end
`endif
      default: w_next_state = S_REQ;
    endcase

    // Redirect wins over everything; kill marks whichever response is still owed.
    if (i_redirect) begin
      w_capture = 1'b0;
      w_next_pc = w_redir_pc;
      case (r_state)
        S_REQ:   w_next_kill = w_granted;
        S_RESP:  w_next_kill = !i_imem_rvalid;
        default: ;
      endcase
`ifdef MISALIGN_TRAP_EN
      if (w_misaligned) begin
        w_next_state    = S_HALT;
        w_next_misalign = 1'b1;
      end else if (r_state == S_HALT) begin
        w_next_state = w_next_kill ? S_RESP : S_REQ;
      end
`endif
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_misalign <= 1'b0;
    else         r_misalign <= w_next_misalign;
  end
  assign o_misalign = r_misalign;
`else
  assign o_misalign = 1'b0;
`endif

  fetch_out_reg u_out_reg (
    .clk          (clk),
    .resetn       (resetn),
    .i_load       (w_capture),
    .i_load_pc    (r_pc),
    .i_load_instr (i_imem_rdata),
    .i_consume    (w_consume),
    .i_flush      (i_redirect),
    .o_valid      (w_if_valid),
    .o_pc         (o_if_pc),
    .o_pc4        (o_if_pc4),
    .o_instr      (o_if_instr)
  );

  assign o_if_valid = w_if_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// scored against a program-order model of the consumed instruction stream.
module tb_fetch_ctrl;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        resetn;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_pc4;
  logic [31:0] o_if_instr;
  logic        o_misalign;

  logic gnt_en;
  int   mem_lat;
  logic m_busy;
  int   m_cnt;
  int   n_checks;
  int   n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_if_valid    (o_if_valid),
    .o_if_pc       (o_if_pc),
    .o_if_pc4      (o_if_pc4),
    .o_if_instr    (o_if_instr),
    .o_misalign    (o_misalign)
  );

  // Instruction memory: grants when enabled, answers addr^KEY mem_lat cycles after the grant.
  assign i_imem_gnt = o_imem_req & gnt_en;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy        <= 1'b0;
      m_cnt         <= 0;
      i_imem_rvalid <= 1'b0;
      i_imem_rdata  <= 32'h0;
    end else begin
      i_imem_rvalid <= 1'b0;
      if (o_imem_req && i_imem_gnt) begin
        m_busy       <= 1'b1;
        i_imem_rdata <= o_imem_addr ^ KEY;
        if (mem_lat <= 1) i_imem_rvalid <= 1'b1;
        else              m_cnt <= mem_lat - 1;
      end else if (m_busy && !i_imem_rvalid) begin
        if (m_cnt <= 1) i_imem_rvalid <= 1'b1;
        else            m_cnt <= m_cnt - 1;
      end else if (i_imem_rvalid) begin
        m_busy <= 1'b0;
      end
    end
  end

  // Every cycle the bench acts one time unit after the falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn        = 1'b0;
    i_stall       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    gnt_en        = 1'b1;
    mem_lat       = 1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_imem_req) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_if_valid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    i_redirect    = 1'b1;
    i_redirect_pc = target;
    cyc();
    i_redirect = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    i_stall    = 1'b0;
    i_redirect = 1'b0;
    gnt_en     = 1'b1;
    mem_lat    = 1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (o_if_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", o_if_valid);
    else n_pass++;
    n_checks++;
    if (o_if_pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h expected 00000000", o_if_pc);
    else n_pass++;
    n_checks++;
    if (o_if_instr !== NOP) $display("[TB] FAIL reset_instr: got %h expected %h", o_if_instr, NOP);
    else n_pass++;
    n_checks++;
    if (o_if_pc4 !== 32'h4) $display("[TB] FAIL reset_pc4: got %h expected 00000004", o_if_pc4);
    else n_pass++;
    n_checks++;
    if (o_misalign !== 1'b0) $display("[TB] FAIL reset_misalign: got %b expected 0", o_misalign);
    else n_pass++;
    n_checks++;
    if (o_imem_addr !== 32'h0) $display("[TB] FAIL reset_addr: got %h expected 00000000", o_imem_addr);
    else n_pass++;
  endtask

  // Zero-wait memory: request on even cycles, instruction visible two cycles after its request.
  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) cyc();
      n_checks++;
      if (o_imem_req !== ((c % 2) == 0)) $display("[TB] FAIL stream_req c%0d: got %b expected %b", c, o_imem_req, ((c % 2) == 0));
      else n_pass++;
      if ((c % 2) == 0) begin
        e = 32'(c * 2);
        n_checks++;
        if (o_imem_addr !== e) $display("[TB] FAIL stream_addr c%0d: got %h expected %h", c, o_imem_addr, e);
        else n_pass++;
      end
      if (c >= 2) begin
        n_checks++;
        if (o_if_valid !== ((c % 2) == 0)) $display("[TB] FAIL stream_valid c%0d: got %b expected %b", c, o_if_valid, ((c % 2) == 0));
        else n_pass++;
        if ((c % 2) == 0) begin
          e = 32'((c - 2) * 2);
          n_checks++;
          if (o_if_pc !== e || o_if_instr !== (e ^ KEY) || o_if_pc4 !== e + 32'd4)
            $display("[TB] FAIL stream_out c%0d: got pc %h instr %h pc4 %h expected pc %h instr %h pc4 %h",
                     c, o_if_pc, o_if_instr, o_if_pc4, e, e ^ KEY, e + 32'd4);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    cyc();
    wait_valid(ok);
    i_stall = 1'b1;
    #1;
    n_checks++;
    if (!ok || o_if_pc !== 32'hC) $display("[TB] FAIL stall_entry: got valid %b pc %h expected valid 1 pc 0000000c", ok, o_if_pc);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (o_imem_req !== 1'b0 || o_if_valid !== 1'b1 || o_if_pc !== 32'hC || o_if_instr !== (32'hC ^ KEY))
        $display("[TB] FAIL stall_hold %0d: got req %b valid %b pc %h instr %h expected req 0 valid 1 pc 0000000c instr %h",
                 i, o_imem_req, o_if_valid, o_if_pc, o_if_instr, 32'hC ^ KEY);
      else n_pass++;
      cyc();
    end
    i_stall = 1'b0;
    #1;
    n_checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h10)
      $display("[TB] FAIL stall_release: got req %b addr %h expected req 1 addr 00000010", o_imem_req, o_imem_addr);
    else n_pass++;
  endtask

  task automatic test_redirect_resp();
    bit ok;
    bit found;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (o_imem_req && o_imem_addr == 32'h8) found = 1'b1;
      else cyc();
    end
    mem_lat = 3;
    cyc();
    mem_lat = 1;
    n_checks++;
    if (!found || o_imem_req !== 1'b0) $display("[TB] FAIL rresp_setup: got found %b req %b expected found 1 req 0", found, o_imem_req);
    else n_pass++;
    pulse_redirect(32'h100);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (o_imem_req) begin
        ok = 1'b1;
        break;
      end
      n_checks++;
      if (o_if_valid !== 1'b0) $display("[TB] FAIL rresp_drop: got valid %b pc %h expected valid 0", o_if_valid, o_if_pc);
      else n_pass++;
      cyc();
    end
    n_checks++;
    if (!ok || o_imem_addr !== 32'h100) $display("[TB] FAIL rresp_addr: got req %b addr %h expected req 1 addr 00000100", ok, o_imem_addr);
    else n_pass++;
    wait_valid(ok);
    n_checks++;
    if (!ok || o_if_pc !== 32'h100 || o_if_instr !== (32'h100 ^ KEY))
      $display("[TB] FAIL rresp_capture: got pc %h instr %h expected pc 00000100 instr %h", o_if_pc, o_if_instr, 32'h100 ^ KEY);
    else n_pass++;
  endtask

  task automatic test_redirect_gnt();
    bit ok;
    bit found;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (o_imem_req && o_imem_addr == 32'hC) found = 1'b1;
      else cyc();
    end
    pulse_redirect(32'h200);
    wait_req(ok);
    n_checks++;
    if (!found || !ok || o_imem_addr !== 32'h200) $display("[TB] FAIL rgnt_addr: got req %b addr %h expected req 1 addr 00000200", ok, o_imem_addr);
    else n_pass++;
    wait_valid(ok);
    n_checks++;
    if (!ok || o_if_pc !== 32'h200 || o_if_instr !== (32'h200 ^ KEY))
      $display("[TB] FAIL rgnt_capture: got pc %h instr %h expected pc 00000200 instr %h", o_if_pc, o_if_instr, 32'h200 ^ KEY);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    pulse_redirect(32'hFFFF_FFFC);
    wait_valid(ok);
    n_checks++;
    if (!ok || o_if_pc !== 32'hFFFF_FFFC || o_if_pc4 !== 32'h0)
      $display("[TB] FAIL wrap_pc4: got pc %h pc4 %h expected pc fffffffc pc4 00000000", o_if_pc, o_if_pc4);
    else n_pass++;
    n_checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0)
      $display("[TB] FAIL wrap_addr: got req %b addr %h expected req 1 addr 00000000", o_imem_req, o_imem_addr);
    else n_pass++;
  endtask

  task automatic test_misalign();
    bit ok;
    pulse_redirect(32'h102);
`ifdef MISALIGN_TRAP_EN
    n_checks++;
    if (o_misalign !== 1'b1 || o_imem_req !== 1'b0)
      $display("[TB] FAIL mis_pulse: got misalign %b req %b expected misalign 1 req 0", o_misalign, o_imem_req);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++;
      if (o_misalign !== 1'b0 || o_imem_req !== 1'b0 || o_if_valid !== 1'b0)
        $display("[TB] FAIL mis_halt %0d: got misalign %b req %b valid %b expected 0 0 0", i, o_misalign, o_imem_req, o_if_valid);
      else n_pass++;
    end
    pulse_redirect(32'h300);
    n_checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h300)
      $display("[TB] FAIL mis_resume: got req %b addr %h expected req 1 addr 00000300", o_imem_req, o_imem_addr);
    else n_pass++;
`else
    n_checks++;
    if (o_misalign !== 1'b0) $display("[TB] FAIL mis_tied: got %b expected 0", o_misalign);
    else n_pass++;
    wait_req(ok);
    n_checks++;
    if (!ok || o_imem_addr !== 32'h100) $display("[TB] FAIL mis_align: got req %b addr %h expected req 1 addr 00000100", ok, o_imem_addr);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_async();
    do_reset();
    cyc();
    resetn = 1'b0;
    #1;
    n_checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0 || o_if_valid !== 1'b0)
      $display("[TB] FAIL async_reset: got req %b addr %h valid %b expected req 1 addr 00000000 valid 0", o_imem_req, o_imem_addr, o_if_valid);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0)
      $display("[TB] FAIL async_restart: got req %b addr %h expected req 1 addr 00000000", o_imem_req, o_imem_addr);
    else n_pass++;
  endtask

  // Program-order model: the next consumed instruction is the last redirect target plus 4 per consumption.
  task automatic test_random();
    logic [31:0] exp_pc;
    int consumed;
    do_reset();
    exp_pc   = 32'h0;
    consumed = 0;
    for (int i = 0; i < 800; i++) begin
      i_stall       = ($urandom_range(0, 3) == 0);
      i_redirect    = ($urandom_range(0, 15) == 0);
      i_redirect_pc = $urandom() & 32'hFFFF_FFFC;
      gnt_en        = ($urandom_range(0, 3) != 0);
      mem_lat       = $urandom_range(1, 3);
      #1;
      if (o_if_valid && i_stall) begin
        n_checks++;
        if (o_imem_req !== 1'b0) $display("[TB] FAIL rand_stall_req cyc %0d: got %b expected 0", i, o_imem_req);
        else n_pass++;
      end
      if (i_redirect) begin
        exp_pc = i_redirect_pc;
      end else if (o_if_valid && !i_stall) begin
        n_checks++;
        if (o_if_pc !== exp_pc || o_if_instr !== (exp_pc ^ KEY) || o_if_pc4 !== exp_pc + 32'd4)
          $display("[TB] FAIL rand_consume cyc %0d: got pc %h instr %h pc4 %h expected pc %h instr %h pc4 %h",
                   i, o_if_pc, o_if_instr, o_if_pc4, exp_pc, exp_pc ^ KEY, exp_pc + 32'd4);
        else n_pass++;
        exp_pc   = exp_pc + 32'd4;
        consumed = consumed + 1;
      end
      cyc();
    end
    i_stall    = 1'b0;
    i_redirect = 1'b0;
    gnt_en     = 1'b1;
    n_checks++;
    if (consumed < 40) $display("[TB] FAIL rand_progress: got %0d consumed expected at least 40", consumed);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_resp();
    test_redirect_gnt();
    test_wrap();
    test_misalign();
    test_reset_async();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
